// File: rtl/serial_load_rx.sv
// Oversampling serial receiver that feeds the enabled flop bank: one load_en strobe per good LSB-first frame.
// Define SERIAL_LOAD_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_load_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 load_en,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef SERIAL_LOAD_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   mid_bit;
    logic                   par_bad;
    logic                   sample;
    logic                   load_d;
    logic                   err_d;

    // Two-flop synchronizer; idle-high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign mid_bit = (cnt == FULL_LAST);

`ifdef SERIAL_LOAD_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (state_q == S_PARITY && sample)
            par_err_q <= rx_s ^ (^shift_q);
    end

    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (!rx_s) state_d = S_START;
            S_START:     if (cnt == HALF_LAST) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (mid_bit && bit_idx == IDX_LAST) begin
`ifdef SERIAL_LOAD_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef SERIAL_LOAD_PARITY_EN
            S_PARITY:    if (mid_bit) state_d = S_STOP;
`endif
            // A low stop bit means the line may be in break: wait for it to rise
            S_STOP:      if (mid_bit) state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sample = 1'b0;
        load_d = 1'b0;
        err_d  = 1'b0;
        busy   = (state_q != S_IDLE);
        case (state_q)
            S_START:  sample = (cnt == HALF_LAST);
            S_DATA:   sample = mid_bit;
`ifdef SERIAL_LOAD_PARITY_EN
            S_PARITY: sample = mid_bit;
`endif
            S_STOP: begin
                sample = mid_bit;
                load_d = mid_bit && rx_s && !par_bad;
                err_d  = mid_bit && !(rx_s && !par_bad);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            load_en   <= 1'b0;
            frame_err <= 1'b0;
            data_out  <= '0;
        end else begin
            load_en   <= load_d;
            frame_err <= err_d;
            if (load_d)
                data_out <= shift_q;
            if (state_q == S_IDLE || sample || state_d != state_q)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (state_q == S_START)
                bit_idx <= '0;
            else if (state_q == S_DATA && sample)
                bit_idx <= bit_idx + IW'(1);
        end
    end

    // LSB arrives first, so each new bit enters at the top and walks down
    always_ff @(posedge clk) begin
        if (state_q == S_DATA && sample)
            shift_q <= (shift_q >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
    end

endmodule

// File: tb/tb_serial_load_rx.sv
// Directed bench for serial_load_rx: good frames, back-to-back frames, glitch, break, mid-frame reset.
module tb_serial_load_rx;

    localparam int C = 16;
    localparam int D = 8;
`ifdef SERIAL_LOAD_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int STOP_OFS = 2 + C / 2 + (D + 1 + P) * C;
    localparam int FRAME    = (D + 2 + P) * C;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       load_en;
    logic       frame_err;
    logic       busy;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int e0 = 0;
    int e0a = 0;
    int both = 0;
    int load_q[$];
    int ldata_q[$];
    int err_q[$];

    serial_load_rx #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .data_out(data_out),
        .load_en(load_en),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log, taken mid-cycle; cyc here is the index of the edge just passed
    always @(negedge clk) begin
        if (reset) begin
            if (load_en) begin
                load_q.push_back(cyc);
                ldata_q.push_back(int'(data_out));
            end
            if (frame_err) err_q.push_back(cyc);
            if (load_en && frame_err) both++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        e0 = cyc + 1;
        drive(1'b0, C);
        for (int i = 0; i < D; i++) drive(d[i], C);
`ifdef SERIAL_LOAD_PARITY_EN
        drive((^d) ^ par_flip, C);
`endif
        drive(stop_v, C);
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", int'(data_out), 0);
        chk("rst_load", int'(load_en), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_strobes", load_q.size() + err_q.size(), 0);

        // 0xA5 with good stop bit
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("a5_count", load_q.size(), 1);
        chk("a5_edge", load_q[0], e0 + STOP_OFS);
        chk("a5_strobe_data", ldata_q[0], 'hA5);
        chk("a5_hold", int'(data_out), 'hA5);
        chk("a5_err", err_q.size(), 0);
        chk("a5_busy", int'(busy), 0);

        // 0x3C then 0xFF with no idle gap
        send_frame(8'h3C, 1'b1, 1'b0);
        e0a = e0;
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("b2b_count", load_q.size(), 3);
        chk("b2b_edge", load_q[1], e0a + STOP_OFS);
        chk("b2b_gap", load_q[2] - load_q[1], FRAME);
        chk("b2b_data0", ldata_q[1], 'h3C);
        chk("b2b_data1", ldata_q[2], 'hFF);

        // 5-cycle low glitch
        e0 = cyc + 1;
        drive(1'b0, 5);
        chk("glitch_busy_hi", int'(busy), 1);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        chk("glitch_busy_lo", int'(busy), 0);
        chk("glitch_strobes", load_q.size() * 16 + err_q.size(), 3 * 16);

        // 0x55 with low stop bit, line held in break
        send_frame(8'h55, 1'b0, 1'b0);
        drive(1'b0, 300);
        chk("brk_err_count", err_q.size(), 1);
        chk("brk_err_edge", err_q[0], e0 + STOP_OFS);
        chk("brk_no_load", load_q.size(), 3);
        chk("brk_data_held", int'(data_out), 'hFF);
        chk("brk_busy_hi", int'(busy), 1);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("brk_busy_lo", int'(busy), 0);
        repeat (20) @(negedge clk);
        chk("brk_no_retrig", err_q.size() * 16 + load_q.size(), 16 + 3);

        // Reset during data bit 3 of 0x81
        drive(1'b0, C);
        drive(1'b1, C);
        drive(1'b0, C);
        drive(1'b0, C);
        rx = 1'b0;
        repeat (C / 2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_data", int'(data_out), 0);
        rx    = 1'b1;
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_strobes", load_q.size() * 16 + err_q.size(), 3 * 16 + 1);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("r81_count", load_q.size(), 4);
        chk("r81_edge", load_q[3], e0 + STOP_OFS);
        chk("r81_data", int'(data_out), 'h81);

`ifdef SERIAL_LOAD_PARITY_EN
        // Wrong parity on 0x81 with a good stop bit
        send_frame(8'h81, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("par_err_count", err_q.size(), 2);
        chk("par_err_edge", err_q[1], e0 + STOP_OFS);
        chk("par_no_load", load_q.size(), 4);
        chk("par_busy", int'(busy), 0);
        chk("par_data_held", int'(data_out), 'h81);
`endif

        chk("exclusive", both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_load_rx.md
# serial_load_rx

Serial-to-parallel receive stage that sits directly upstream of the team's enabled D flip-flop register bank. It oversamples an asynchronous UART-style serial line and assembles LSB-first frames. For each good frame it presents the word on `data_out` and pulses `load_en` for one cycle; `load_en` drives the `en` pins of the downstream flop bank and `data_out` drives their `d` pins.

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; even, ≥4.
- `DATA_BITS`, 8: payload bits per frame; 1–16.
- `clk`  input  1  system clock; all state is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `rx`  input  1  raw serial line; idle high; asynchronous to clk.
- `data_out`  output  DATA_BITS  last good word received; held between frames.
- `load_en`  output  1  one-cycle strobe; `data_out` is valid and new in this cycle.
- `frame_err`  output  1  one-cycle strobe when the stop bit (or parity) is bad.
- `busy`  output  1  high in every state except IDLE.

## Operation
- Input path: 2-flop synchronizer on `rx` produces `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- Let H = CLKS_PER_BIT/2 and C = CLKS_PER_BIT. The bit counter `cnt` clears on every state entry and after every sample.
- States: IDLE, START, DATA, PARITY (only when the macro is defined), STOP, WAIT_HIGH.
- IDLE: `rx_s`==0 → START.
- START: sample when cnt==H-1. If `rx_s`==1 (glitch), go to IDLE with no strobe. Otherwise go to DATA with bit index 0.
- DATA: sample when cnt==C-1 and shift into the shift register LSB-first. After sampling bit DATA_BITS-1, go to PARITY if enabled, otherwise STOP.
- STOP: sample when cnt==C-1.
  - `rx_s`==1 and no parity error: `data_out` ← shift register, `load_en` pulses, go to IDLE.
  - Otherwise: `frame_err` pulses, `data_out` is unchanged, no `load_en`, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This stops a held-low line (break) from retriggering frames.
- Back-to-back frames: IDLE may detect the next start bit on the edge right after the STOP sample. No extra idle time is required beyond the stop bit.
- `load_en` and `frame_err` are never high in the same cycle. Each is high for exactly one cycle per frame.

## Timing
- Reset (async assert, sync-free release): `data_out`=0, `load_en`=0, `frame_err`=0, `busy`=0, state=IDLE, synchronizer=1. Reset mid-frame discards the partial frame with no strobe.
- Let E0 be the first posedge at which raw `rx` is sampled 0. IDLE sees `rx_s`==0 at E0+2, and `busy` goes high after that edge.
- Sample edges:
  - Start bit: E0+2+H.
  - Data bit k: E0+2+H+(k+1)·C.
  - Parity bit (if enabled): E0+2+H+(DATA_BITS+1)·C.
  - Stop bit: E0+2+H+(DATA_BITS+1+P)·C, where P=1 with parity and 0 without.
- `load_en`/`frame_err` are high for the cycle following the stop-sample edge. `busy` drops in that same cycle, unless the state is WAIT_HIGH.
- The `data_out` update and the `load_en` rise occur on the same edge, so the downstream flop captures the new word on the next edge.
- Receiver tolerance: mid-bit sampling tolerates ≤ ±H-1 cycles of accumulated drift over a frame.

## Configuration
- `SERIAL_LOAD_PARITY_EN` defined: adds one even-parity bit after the data bits, in the PARITY state sampled at cnt==C-1.
  - A parity mismatch is treated as a bad stop bit: `frame_err` pulses, there is no `load_en`, and the next state is WAIT_HIGH if `rx_s`==0 at the stop sample, otherwise IDLE.
  - Frame length is 1+DATA_BITS+1+1 bits.
- Undefined: no PARITY state or logic, and the frame is 1+DATA_BITS+1 bits.

## Test plan
- Reset with `rx`=1, then release → all outputs 0. Hold 200 cycles → `busy`=0, no strobes.
- C=16, D=8, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first) with a good stop bit → `load_en` high for exactly 1 cycle after edge E0+154, `data_out`=0xA5, `frame_err`=0.
- Send 0x3C immediately followed by 0xFF with no idle gap → two `load_en` pulses exactly 160 cycles apart; `data_out` = 0x3C, then 0xFF.
- Drive `rx` low for 5 cycles, then high → `busy` rises, START rejects it, no strobe, back in IDLE by E0+11.
- Send 0x55 with the stop bit 0 and hold `rx` low for 300 cycles → `frame_err` pulses once, `data_out` keeps its previous value, `busy` stays high until `rx` returns to 1, no retrigger.
- Assert `reset` at the 4th data bit of 0x81, release, then send 0x81 → no strobe from the aborted frame; the new frame gives `data_out`=0x81. With `SERIAL_LOAD_PARITY_EN` defined, a wrong parity bit on 0x81 → `frame_err` and no `load_en`.
